fft_r2_stage: RTL and testbench
===============================

# fft_r2_stage

Streaming radix-2 decimation-in-time butterfly stage, placed directly downstream of `bitrev`. It consumes complex samples in bit-reversed frame order and pairs samples 2^S apart within each block of 2·2^S. It applies the stage twiddle and emits the butterfly results in stage-natural order through a valid/ready stream. K instances with S = 0..K-1 chained after `bitrev` form a full N = 2^K-point FFT.

## Interface
- `K`, 10, log2 of frame length N
- `S`, 0, stage index, 0 ≤ S < K; span M = 2^S
- `DW`, 32, sample width; [DW-1:DW/2] real, [DW/2-1:0] imag, signed Q1.15; only DW = 32 supported
- `clk_i` in 1, single clock
- `rst_i` in 1, synchronous, active-high reset
- `valid_i` in 1, input sample valid
- `data_i` in DW, input complex sample
- `ready_o` out 1, stage accepts `data_i`
- `valid_o` out 1, output sample valid
- `data_o` out DW, output complex sample
- `ready_i` in 1, downstream accepts `data_o`

## Operation
- Buffer: M complex words, indexed by j = in-block offset mod M. Each slot is read before it is written in the same cycle.
- `adv = !valid_o || ready_i` (output register free or draining).
- States and transitions:
  - FILL: `ready_o = 1`. Each accepted word a_j is stored to buf[j]. No output. After M accepts, go to COMBINE.
  - COMBINE: `ready_o = adv`. On accept of b_j:
    - t = b_j·W_j.
    - Load the output register with (buf[j] + t)/2.
    - Write buf[j] ← (buf[j] − t)/2.
    - After M accepts, go to DRAIN if this was the last block of the frame (input count = N−1), otherwise go to SWAP.
  - SWAP: `ready_o = adv`. On accept of a_j, load the output register with buf[j] and write buf[j] ← a_j. After M accepts, go to COMBINE.
  - DRAIN: `ready_o = 0`. When `adv`, load the output register with buf[j]. After M outputs, go to FILL.
- Twiddle W_j = exp(−iπj/M):
  - wr = round(16384·cos(πj/M)), wi = round(−16384·sin(πj/M)).
  - Signed 16-bit Q1.14. j = 0 gives (16384, 0).
- Arithmetic per component:
  - t_re = (br·wr − bi·wi + 2^13) >>> 14; t_im = (br·wi + bi·wr + 2^13) >>> 14. Keep 18 bits.
  - Sum/difference computed at 19 bits, then arithmetic shift right by 1 (floor).
  - Result saturated to [−32768, 32767].
- Counters:
  - In-block offset: S-bit.
  - Frame input counter: K-bit, wraps at N.
  - Drain counter: reuses the offset counter.
- Frames may arrive back-to-back. The FILL of frame f+1 begins only after the DRAIN of frame f.

## Timing
- Reset values: state FILL, all counters 0, `valid_o = 0`, `data_o = 0`. `ready_o = 1` from the first cycle after reset. Buffer contents are not reset and are never emitted before being rewritten.
- Reset asserted mid-frame: the next cycle is FILL with an empty output register. The partial frame is discarded.
- Output is registered: 1-cycle latency from accept to `valid_o`.
- First output of a frame appears M+1 accepted-input cycles after the frame's first accept.
- Steady-state throughput is 1 sample/cycle within a frame. There are M bubbles of input (DRAIN) and M of output (FILL) at each frame boundary.
- `ready_o` depends combinationally on `ready_i` in COMBINE and SWAP. There is no combinational path from `valid_i` to `valid_o`.
- `data_o` holds stable while `valid_o && !ready_i`.
- An input accept and an output handshake in the same cycle are legal and required for full rate.

## Structure
- `fft_pkg`:
  - `cplx_t` packed struct {re, im: logic signed [15:0]}
  - twiddle width constant (16) and fraction (14)
  - constant function `twiddle(j, M)` returning `cplx_t`
  - function `sat16`
- Sub-module `fft_twiddle_rom` #(S): M-entry combinational ROM, elaborated from `fft_pkg::twiddle`.
- The buffer is a plain register array with one read port and one write port.

## Test plan
- Reset mid-COMBINE (K=3, S=1, after 3 accepts), then a clean frame → `valid_o` 0 the next cycle; output matches the golden model for the clean frame only.
- K=2, S=0, input (0x2000,0),(0x1000,0),(0x0400,0),(0x0400,0) → outputs (0x1800,0),(0x0800,0),(0x0400,0),(0x0000,0).
- K=2, S=1, input a0=a1=(0x1000,0), b0=(0,0), b1=(0x2000,0); W1=(0,−16384) → outputs (0x0800,0),(0x0800,0xF000),(0x0800,0),(0x0800,0x1000).
- K=3, S=2, a1=b1=(0x7FFF,0x7FFF), W1=(11585,−11585) → upper1 real saturates to 0x7FFF.
- K=4, S=2, random data, `ready_i` toggling 1/0 each cycle → all 16 outputs match the golden model with no loss or duplication.
- K=3, S=1, three back-to-back frames with `ready_i = 1` → 24 outputs match the golden model; exactly M = 2 input-stall cycles at each frame boundary.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT stages.
// Twiddles are Q1.14 and are resolved entirely at elaboration time.
package fft_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  localparam int TW_W = 16;
  localparam int TW_F = 14;
  localparam real PI = 3.14159265358979323846;

  function automatic int round_real(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic cplx_t twiddle(int j, int m);
    real ph;
    real sc;
    cplx_t w;
    ph = PI * real'(j) / real'(m);
    sc = real'(1 << TW_F);
    w.re = TW_W'(round_real(sc * $cos(ph)));
    w.im = TW_W'(round_real(-sc * $sin(ph)));
    return w;
  endfunction

  function automatic logic signed [15:0] sat16(
    logic signed [18:0] v
  );
    if (v > 19'sd32767) return 16'sh7fff;
    if (v < -19'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// M-entry constant twiddle table for one butterfly stage.
// Entry j holds exp(-i*pi*j/M) in Q1.14.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int S  = 0,
  parameter int JW = (S > 0) ? S : 1
) (
  input  logic [JW-1:0] j,
  output cplx_t         w
);

  localparam int M = 1 << S;

  cplx_t rom [M];

  for (genvar g = 0; g < M; g++) begin : g_rom
    localparam cplx_t W = twiddle(g, M);
    assign rom[g] = W;
  end

  assign w = rom[j];

endmodule

// File: rtl/fft_r2_stage.sv
// Streaming radix-2 DIT butterfly stage with span 2^S.
// Holds the upper half of each block while the lower half streams in.
module fft_r2_stage
  import fft_pkg::*;
#(
  parameter int K  = 10,
  parameter int S  = 0,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i
);

  localparam int M  = 1 << S;
  localparam int N  = 1 << K;
  localparam int JW = (S > 0) ? S : 1;

  typedef enum logic [1:0] {
    FILL,
    COMBINE,
    SWAP,
    DRAIN
  } state_t;

  state_t state;

  logic [JW-1:0] j;
  logic [JW-1:0] nj;
  logic [K-1:0]  cnt;

  cplx_t mem [M];
  cplx_t rd;
  cplx_t b;
  cplx_t w;
  cplx_t up;
  cplx_t lo;
  cplx_t wdat;

  logic adv;
  logic acc;
  logic we;
  logic last_j;
  logic last_in;

  logic signed [31:0] pre;
  logic signed [31:0] pim;
  logic signed [17:0] tre;
  logic signed [17:0] tim;
  logic signed [18:0] sr;
  logic signed [18:0] si;
  logic signed [18:0] dr;
  logic signed [18:0] di;

  fft_twiddle_rom #(
    .S  (S),
    .JW (JW)
  ) u_rom (
    .j (j),
    .w (w)
  );

  assign b  = data_i;
  assign rd = mem[j];

  assign adv     = !valid_o || ready_i;
  assign acc     = valid_i && ready_o;
  assign last_j  = (j == JW'(M - 1));
  assign last_in = (cnt == K'(N - 1));
  assign nj      = last_j ? '0 : j + JW'(1);

  // Rounded Q1.14 product, kept at 18 bits.
  assign pre = b.re * w.re - b.im * w.im + 32'sd8192;
  assign pim = b.re * w.im + b.im * w.re + 32'sd8192;
  assign tre = 18'(pre >>> TW_F);
  assign tim = 18'(pim >>> TW_F);

  assign sr = 19'(rd.re) + 19'(tre);
  assign si = 19'(rd.im) + 19'(tim);
  assign dr = 19'(rd.re) - 19'(tre);
  assign di = 19'(rd.im) - 19'(tim);

  assign up.re = sat16(sr >>> 1);
  assign up.im = sat16(si >>> 1);
  assign lo.re = sat16(dr >>> 1);
  assign lo.im = sat16(di >>> 1);

  always_comb begin
    ready_o = 1'b0;
    we      = 1'b0;
    wdat    = b;
    unique case (state)
      FILL: begin
        ready_o = 1'b1;
        we      = acc;
      end
      COMBINE: begin
        ready_o = adv;
        we      = acc;
        wdat    = lo;
      end
      SWAP: begin
        ready_o = adv;
        we      = acc;
      end
      default: ready_o = 1'b0;
    endcase
  end

  // Read-before-write: rd sees the old slot this cycle.
  always_ff @(posedge clk_i) begin
    if (we) mem[j] <= wdat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= FILL;
      j       <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      if (ready_i) valid_o <= 1'b0;
      unique case (state)
        FILL: begin
          if (acc) begin
            j   <= nj;
            cnt <= cnt + K'(1);
            if (last_j) state <= COMBINE;
          end
        end
        COMBINE: begin
          if (acc) begin
            data_o  <= up;
            valid_o <= 1'b1;
            j       <= nj;
            cnt     <= cnt + K'(1);
            if (last_j) state <= last_in ? DRAIN : SWAP;
          end
        end
        SWAP: begin
          if (acc) begin
            data_o  <= rd;
            valid_o <= 1'b1;
            j       <= nj;
            cnt     <= cnt + K'(1);
            if (last_j) state <= COMBINE;
          end
        end
        DRAIN: begin
          if (adv) begin
            data_o  <= rd;
            valid_o <= 1'b1;
            j       <= nj;
            if (last_j) state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_r2_stage.sv
// Bench for fft_r2_stage: five instances at different K/S,
// directed vectors plus random frames against a block-level FFT model.
module tb_fft_r2_stage;

  localparam int NI = 5;
  localparam int KP [NI] = '{3, 2, 2, 3, 4};
  localparam int SP [NI] = '{1, 0, 1, 2, 2};
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  logic vi [NI];
  logic ri [NI];
  logic ro [NI];
  logic vo [NI];
  logic [31:0] di [NI];
  logic [31:0] dout [NI];

  int ncmp = 0;
  int nmis = 0;
  int stalls;
  logic [31:0] in_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] tmp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fft_r2_stage #(
      .K  (KP[g]),
      .S  (SP[g]),
      .DW (32)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (vi[g]),
      .data_i  (di[g]),
      .ready_o (ro[g]),
      .valid_o (vo[g]),
      .data_o  (dout[g]),
      .ready_i (ri[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] expv);
    ncmp++;
    assert (got === expv) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic [15:0] sat(int v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Whole-frame butterfly: x[base+j] pairs with x[base+m+j].
  task automatic model(input int k, input int s);
    int n, m, ar, ai, br, bi, wr, wi, tr, ti;
    logic [31:0] xa, xb;
    logic [31:0] y [64];
    n = 1 << k;
    m = 1 << s;
    exp_q.delete();
    for (int f = 0; f < in_q.size() / n; f++) begin
      for (int base = 0; base < n; base += 2 * m) begin
        for (int jj = 0; jj < m; jj++) begin
          xa = in_q[f*n + base + jj];
          xb = in_q[f*n + base + m + jj];
          ar = $signed(xa[31:16]);
          ai = $signed(xa[15:0]);
          br = $signed(xb[31:16]);
          bi = $signed(xb[15:0]);
          wr = rnd(16384.0 * $cos(PI * real'(jj) / real'(m)));
          wi = rnd(-16384.0 * $sin(PI * real'(jj) / real'(m)));
          tr = (br * wr - bi * wi + 8192) >>> 14;
          ti = (br * wi + bi * wr + 8192) >>> 14;
          y[base + jj]     = {sat((ar + tr) >>> 1), sat((ai + ti) >>> 1)};
          y[base + m + jj] = {sat((ar - tr) >>> 1), sat((ai - ti) >>> 1)};
        end
      end
      for (int i = 0; i < n; i++) exp_q.push_back(y[i]);
    end
  endtask

  task automatic run(input int id, input int rmode);
    int ip, op, cyc;
    logic hold;
    logic [31:0] hd;
    ip = 0;
    op = 0;
    cyc = 0;
    hold = 1'b0;
    hd = '0;
    stalls = 0;
    got_q.delete();
    while ((ip < in_q.size() || op < exp_q.size()) && cyc < 4000) begin
      @(negedge clk);
      ri[id] = (rmode == 0) ? 1'b1 : ~cyc[0];
      vi[id] = (ip < in_q.size());
      di[id] = vi[id] ? in_q[ip] : '0;
      #1;
      if (hold) begin
        chk("hold_valid", 32'(vo[id]), 32'd1);
        chk("hold_data", dout[id], hd);
      end
      hold = vo[id] && !ri[id];
      hd = dout[id];
      if (vo[id] && ri[id]) begin
        if (op < exp_q.size())
          chk($sformatf("out%0d_%0d", id, op), dout[id], exp_q[op]);
        got_q.push_back(dout[id]);
        op++;
      end
      if (vi[id] && ro[id]) ip++;
      else if (vi[id]) stalls++;
      cyc++;
    end
    @(negedge clk);
    vi[id] = 1'b0;
    ri[id] = 1'b1;
    #1;
    chk($sformatf("count%0d", id), got_q.size(), in_q.size());
    chk($sformatf("idle%0d", id), 32'(vo[id]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      vi[i] = 1'b0;
      ri[i] = 1'b1;
      di[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(vo[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), dout[i], 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(ro[i]), 32'd1);
    end

    // Reset partway into COMBINE on K=3,S=1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vi[0] = 1'b1;
      di[0] = $urandom;
    end
    @(negedge clk);
    vi[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("pre_rst_valid", 32'(vo[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(vo[0]), 32'd0);
    chk("post_rst_ready", 32'(ro[0]), 32'd1);

    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back($urandom);
    model(3, 1);
    run(0, 0);

    // Three back-to-back frames.
    in_q.delete();
    for (int i = 0; i < 24; i++) in_q.push_back($urandom);
    model(3, 1);
    run(0, 0);
    chk("b2b_stalls", stalls, 32'd4);

    in_q = '{32'h2000_0000, 32'h1000_0000, 32'h0400_0000, 32'h0400_0000};
    exp_q = '{32'h1800_0000, 32'h0800_0000, 32'h0400_0000, 32'h0000_0000};
    run(1, 0);

    in_q = '{32'h1000_0000, 32'h1000_0000, 32'h0000_0000, 32'h2000_0000};
    exp_q = '{32'h0800_0000, 32'h0800_f000, 32'h0800_0000, 32'h0800_1000};
    run(2, 0);

    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back($urandom);
    in_q[1] = 32'h7fff_7fff;
    in_q[5] = 32'h7fff_7fff;
    model(3, 2);
    run(3, 0);
    tmp = (got_q.size() > 1) ? got_q[1] : '0;
    chk("sat_upper1_re", 32'(tmp[31:16]), 32'h0000_7fff);

    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back($urandom);
    model(4, 2);
    run(4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
